// File: rtl/seq_det_ctrl_if.sv
// Host/config, serial-input and status bundle for seq_det_ctrl.
// master = host side driving config/start/stream, slave = detector.
interface seq_det_ctrl_if #(
  parameter int PW = 5,
  parameter int CW = 8
);
  logic          cfg_we;
  logic [PW-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_target;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in;
  logic          busy;
  logic          match;
  logic [CW-1:0] match_cnt;
  logic          done;
  logic          cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, in_valid, in,
    input  busy, match, match_cnt, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, in_valid, in,
    output busy, match, match_cnt, done, cfg_err
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with run control: match one cycle after the hit bit,
// done one cycle after the final match; the stream is qualified by in_valid, no stall path.
module seq_det_ctrl #(
  parameter int PW = 5,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] pat_q;
  logic [3:0]    len_q;
  logic          ovl_q;
  logic [CW-1:0] tgt_q;
  logic [PW-1:0] win;
  logic [3:0]    fill;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          match_q;
  logic          done_q;
  logic          err_q;

  logic [3:0]    eff_len;
  logic [CW-1:0] eff_tgt;
  logic          legal;
  logic [PW-1:0] new_win;
  logic [PW-1:0] mask;
  logic [3:0]    fill_inc;
  logic [3:0]    fill_nxt;
  logic          hit;
  logic          last;

  // A same-cycle cfg_we is visible to start, so legality uses the incoming fields.
  always_comb begin
    eff_len  = bus.cfg_we ? bus.cfg_len    : len_q;
    eff_tgt  = bus.cfg_we ? bus.cfg_target : tgt_q;
    legal    = (eff_len != 4'd0) && (eff_len <= 4'(PW)) && (eff_tgt != '0);
    new_win  = {win[PW-2:0], bus.in};
    mask     = ~({PW{1'b1}} << len_q);
    fill_inc = fill + 4'd1;
    fill_nxt = (fill_inc > len_q) ? len_q : fill_inc;
    hit      = (fill_inc >= len_q) && ((new_win & mask) == (pat_q & mask));
    last     = ((cnt + CW'(1)) == tgt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= 4'(PW);
      ovl_q   <= 1'b1;
      tgt_q   <= CW'(1);
      win     <= '0;
      fill    <= 4'd0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            pat_q <= bus.cfg_pattern;
            len_q <= bus.cfg_len;
            ovl_q <= bus.cfg_overlap;
            tgt_q <= bus.cfg_target;
            err_q <= 1'b0;
          end
          if (bus.start) begin
            if (legal) begin
              state  <= RUN;
              busy_q <= 1'b1;
              win    <= '0;
              fill   <= 4'd0;
              cnt    <= '0;
              err_q  <= 1'b0;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins over a completing bit: that bit is never evaluated.
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.in_valid) begin
            win <= new_win;
            if (hit) begin
              match_q <= 1'b1;
              cnt     <= cnt + CW'(1);
              fill    <= ovl_q ? fill_nxt : 4'd0;
              if (last) begin
                state  <= DONE;
                busy_q <= 1'b0;
              end
            end else begin
              fill <= fill_nxt;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;

endmodule
